// File: rtl/sort_engine.sv
// In-place exchange sort of DEPTH words held in an external 1-cycle-latency RAM.
// Define SORT_SIGNED_EN to compare elements as two's-complement; default is unsigned.
module sort_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_desc,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO    = ADDR_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_CMP,
    S_WRI,
    S_WRJ,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_iIdx;
  logic [ADDR_W-1:0]   r_jIdx;
  logic [DATA_W-1:0]   r_opA;
  logic [DATA_W-1:0]   r_opB;
  logic                r_desc;
  logic                r_aLoad;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_busy;
  logic                r_done;

  logic w_aGtB;
  logic w_aLtB;
  logic w_outOfOrder;
  logic w_advance;

  // In CMP the B operand is compared straight off the RAM read port.
  always_comb begin
`ifdef SORT_SIGNED_EN
    w_aGtB = $signed(r_opA) > $signed(i_mem_rdata);
    w_aLtB = $signed(r_opA) < $signed(i_mem_rdata);
`else
    w_aGtB = r_opA > i_mem_rdata;
    w_aLtB = r_opA < i_mem_rdata;
`endif
    w_outOfOrder = r_desc ? w_aLtB : w_aGtB;
    w_advance    = ((r_state == S_CMP) && !w_outOfOrder) || (r_state == S_WRJ);
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_we    = r_we;
  assign o_mem_wdata = r_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  // Outputs are loaded alongside the next state so they are valid for the whole state cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_iIdx  <= '0;
      r_jIdx  <= ONE;
      r_opA   <= '0;
      r_opB   <= '0;
      r_desc  <= 1'b0;
      r_aLoad <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      if (r_state == S_CMP) begin
        r_opB <= i_mem_rdata;
      end
      if (w_advance) begin
        if (r_jIdx < LAST_J) begin
          r_jIdx  <= r_jIdx + ONE;
          r_addr  <= r_jIdx + ONE;
          r_state <= S_RDB;
        end else if (r_iIdx < LAST_I) begin
          r_iIdx  <= r_iIdx + ONE;
          r_jIdx  <= r_iIdx + TWO;
          r_addr  <= r_iIdx + ONE;
          r_state <= S_RDA;
        end else begin
          r_addr  <= '0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_iIdx <= '0;
            r_jIdx <= ONE;
            r_addr <= '0;
            if (i_start) begin
              r_desc  <= i_desc;
              r_busy  <= 1'b1;
              r_state <= S_RDA;
            end
          end
          S_RDA: begin
            r_aLoad <= 1'b1;
            r_addr  <= r_jIdx;
            r_state <= S_RDB;
          end
          // Only the first RDB after RDA carries M[i]; later ones read stale data.
          S_RDB: begin
            if (r_aLoad) begin
              r_opA <= i_mem_rdata;
            end
            r_aLoad <= 1'b0;
            r_state <= S_CMP;
          end
          S_CMP: begin
            r_we    <= 1'b1;
            r_addr  <= r_iIdx;
            r_wdata <= i_mem_rdata;
            r_state <= S_WRI;
          end
          // A follows the new M[i] so later compares in this i pass see it.
          S_WRI: begin
            r_opA   <= r_opB;
            r_we    <= 1'b1;
            r_addr  <= r_jIdx;
            r_wdata <= r_opA;
            r_state <= S_WRJ;
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_iIdx  <= '0;
            r_jIdx  <= ONE;
            r_addr  <= '0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// Testbench for sort_engine: a DEPTH=4 and a DEPTH=2 instance, each on a behavioural
// synchronous RAM, checked against an array-level reference sort.
module tb_sort_engine;

   localparam int DW  = 8;
   localparam int D4  = 4;
   localparam int AW4 = 2;
   localparam int D2  = 2;
   localparam int AW2 = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // DEPTH=4 instance and its RAM
   logic           start4 = 1'b0;
   logic           desc4 = 1'b0;
   logic [DW-1:0]  rdata4;
   logic [AW4-1:0] addr4;
   logic           we4;
   logic [DW-1:0]  wdata4;
   logic           busy4;
   logic           done4;
   logic [DW-1:0]  ram4 [D4];
   logic [DW-1:0]  loadData4 [D4];
   logic           loadEn4 = 1'b0;

   // DEPTH=2 instance and its RAM
   logic           start2 = 1'b0;
   logic           desc2 = 1'b0;
   logic [DW-1:0]  rdata2;
   logic [AW2-1:0] addr2;
   logic           we2;
   logic [DW-1:0]  wdata2;
   logic           busy2;
   logic           done2;
   logic [DW-1:0]  ram2 [D2];
   logic [DW-1:0]  loadData2 [D2];
   logic           loadEn2 = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sort_engine #(.DATA_W(DW), .DEPTH(D4), .ADDR_W(AW4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_desc(desc4),
      .i_mem_rdata(rdata4), .o_mem_addr(addr4), .o_mem_we(we4),
      .o_mem_wdata(wdata4), .o_busy(busy4), .o_done(done4)
   );

   sort_engine #(.DATA_W(DW), .DEPTH(D2), .ADDR_W(AW2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_desc(desc2),
      .i_mem_rdata(rdata2), .o_mem_addr(addr2), .o_mem_we(we2),
      .o_mem_wdata(wdata2), .o_busy(busy2), .o_done(done2)
   );

   // Single-port RAMs with one-cycle read latency plus a whole-array backdoor load
   always @(posedge clk) begin
      if (loadEn4) ram4 <= loadData4;
      else if (we4) ram4[addr4] <= wdata4;
      rdata4 <= ram4[addr4];
   end

   always @(posedge clk) begin
      if (loadEn2) ram2 <= loadData2;
      else if (we2) ram2[addr2] <= wdata2;
      rdata2 <= ram2[addr2];
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Element ordering rule, signedness chosen by the same build macro as the design
   function automatic bit refOutOfOrder(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit dsc);
      int av;
      int bv;
`ifdef SORT_SIGNED_EN
      av = int'($signed(a));
      bv = int'($signed(b));
`else
      av = int'(a);
      bv = int'(b);
`endif
      return dsc ? (av < bv) : (av > bv);
   endfunction

   // Array-level exchange sort: final contents and number of swaps performed
   task automatic refSort(input logic [DW-1:0] inA [D4], input bit dsc,
                          output logic [DW-1:0] outA [D4], output int swaps);
      logic [DW-1:0] t;
      outA = inA;
      swaps = 0;
      for (int i = 0; i < D4 - 1; i++) begin
         for (int j = i + 1; j < D4; j++) begin
            if (refOutOfOrder(outA[i], outA[j], dsc)) begin
               t = outA[i];
               outA[i] = outA[j];
               outA[j] = t;
               swaps++;
            end
         end
      end
   endtask

   // Load RAM, run one sort on the DEPTH=4 engine, check timing, writes and contents
   task automatic applyStimulus(input logic [DW-1:0] vals [D4], input bit dsc, input string tag);
      logic [DW-1:0] expA [D4];
      int swaps;
      int expCyc;
      int cyc;
      int weCnt;
      refSort(vals, dsc, expA, swaps);
      expCyc = 2 * swaps;
      for (int i = 0; i < D4 - 1; i++) expCyc += 1 + 2 * (D4 - 1 - i);
      @(negedge clk);
      loadData4 = vals;
      loadEn4 = 1'b1;
      start4 = 1'b1;
      desc4 = dsc;
      @(posedge clk);
      cyc = 0;
      weCnt = 0;
      do begin
         @(negedge clk);
         loadEn4 = 1'b0;
         start4 = 1'b0;
         cyc++;
         if (cyc == 1) checkOutput($sformatf("%s_busyRun", tag), busy4, 1);
         if (we4) weCnt++;
      end while (!done4 && cyc < 200);
      checkOutput($sformatf("%s_doneCycle", tag), cyc, expCyc + 1);
      checkOutput($sformatf("%s_weCycles", tag), weCnt, 2 * swaps);
      @(negedge clk);
      checkOutput($sformatf("%s_busyAfter", tag), busy4, 0);
      checkOutput($sformatf("%s_donePulse", tag), done4, 0);
      for (int i = 0; i < D4; i++)
         checkOutput($sformatf("%s_m%0d", tag, i), ram4[i], expA[i]);
   endtask

   initial begin
      logic [DW-1:0] v [D4];
      int cyc;
      int weCnt;
      int busyCnt;

      $display("[TB] reset state");
      #12;
      checkOutput("rst_busy", busy4, 0);
      checkOutput("rst_done", done4, 0);
      checkOutput("rst_we", we4, 0);
      checkOutput("rst_addr", addr4, 0);
      checkOutput("rst_wdata", wdata4, 0);
      checkOutput("rst_busy2", busy2, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed DEPTH=4 runs");
      v = '{8'd3, 8'd1, 8'd2, 8'd0};
      applyStimulus(v, 1'b0, "asc3120");
      v = '{8'd0, 8'd1, 8'd2, 8'd3};
      applyStimulus(v, 1'b0, "ascSorted");
      v = '{8'd1, 8'd2, 8'd3, 8'd4};
      applyStimulus(v, 1'b1, "desc1234");
      v = '{8'h80, 8'h7F, 8'h00, 8'hFF};
      applyStimulus(v, 1'b0, "signMix");

      $display("[TB] reset during write");
      @(negedge clk);
      v = '{8'd3, 8'd1, 8'd2, 8'd0};
      loadData4 = v;
      loadEn4 = 1'b1;
      start4 = 1'b1;
      desc4 = 1'b0;
      @(posedge clk);
      cyc = 0;
      do begin
         @(negedge clk);
         loadEn4 = 1'b0;
         start4 = 1'b0;
         cyc++;
      end while (!we4 && cyc < 50);
      checkOutput("wri_reached", we4, 1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midRst_busy", busy4, 0);
      checkOutput("midRst_done", done4, 0);
      checkOutput("midRst_we", we4, 0);
      @(negedge clk);
      checkOutput("midRst_m0", ram4[0], 8'd3);
      checkOutput("midRst_m1", ram4[1], 8'd1);
      rst_n = 1'b1;
      v = '{8'd5, 8'd2, 8'd9, 8'd1};
      applyStimulus(v, 1'b0, "afterRst");

      $display("[TB] random DEPTH=4 runs");
      for (int r = 0; r < 24; r++) begin
         for (int k = 0; k < D4; k++) v[k] = DW'($urandom_range(0, 255));
         if (r % 6 == 0) v[1] = v[0];
         applyStimulus(v, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
      end

      $display("[TB] DEPTH=2 runs");
      @(negedge clk);
      loadData2 = '{8'd5, 8'd2};
      loadEn2 = 1'b1;
      start2 = 1'b1;
      desc2 = 1'b0;
      @(posedge clk);
      cyc = 0;
      weCnt = 0;
      do begin
         @(negedge clk);
         loadEn2 = 1'b0;
         start2 = (cyc == 1);
         cyc++;
         if (we2) weCnt++;
      end while (!done2 && cyc < 50);
      start2 = 1'b0;
      checkOutput("d2_doneCycle", cyc, 6);
      checkOutput("d2_weCycles", weCnt, 2);
      busyCnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (busy2) busyCnt++;
      end
      checkOutput("d2_noRerun", busyCnt, 0);
      checkOutput("d2_m0", ram2[0], 8'd2);
      checkOutput("d2_m1", ram2[1], 8'd5);

      @(negedge clk);
      loadData2 = '{8'd9, 8'd3};
      loadEn2 = 1'b1;
      start2 = 1'b1;
      @(posedge clk);
      cyc = 0;
      do begin
         @(negedge clk);
         loadEn2 = 1'b0;
         cyc++;
      end while (!done2 && cyc < 50);
      checkOutput("d2held_done", done2, 1);
      @(negedge clk);
      checkOutput("d2held_idleGap", busy2, 0);
      @(negedge clk);
      checkOutput("d2held_rerun", busy2, 1);
      start2 = 1'b0;
      cyc = 0;
      weCnt = 0;
      while (!done2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (we2) weCnt++;
      end
      checkOutput("d2held_done2", done2, 1);
      checkOutput("d2held_we2", weCnt, 0);
      checkOutput("d2held_m0", ram2[0], 8'd3);
      checkOutput("d2held_m1", ram2[1], 8'd9);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sort_engine.md
# sort_engine

- Self-contained, parametrised exchange-sort engine: the FSM, i/j index counters, A/B operand registers, comparator and write-back mux all live in one block.
- Sorts `DEPTH` words of `DATA_W` bits in place in an external synchronous single-port RAM.
- Ascending or descending order, selected per run; sits between the system start/done handshake and the sort buffer RAM.

## Interface
- `DATA_W`, 8: element width in bits.
- `DEPTH`, 4: number of elements; legal range ≥2.
- `ADDR_W`, `$clog2(DEPTH)`: RAM address width.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `desc`  in  1  order select, captured on start accept: 0 ascending, 1 descending.
- `mem_rdata`  in  `DATA_W`  RAM read data; valid one cycle after `mem_addr`.
- `mem_addr`  out  `ADDR_W`  RAM address.
- `mem_we`  out  1  RAM write enable.
- `mem_wdata`  out  `DATA_W`  RAM write data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Algorithm, index counters i and j:
  - for i = 0..DEPTH-2, for j = i+1..DEPTH-1;
  - A holds M[i], B holds M[j];
  - if out of order, write M[i]=B and M[j]=A.
- Out of order means A>B when ascending and A<B when descending. Equal values never swap.
- States:
  - IDLE: i=0, j=1. On start=1, latch desc and go to RDA.
  - RDA: addr=i. Set `a_load`. Go to RDB.
  - RDB: addr=j. If `a_load`, A<=mem_rdata and clear `a_load`. Go to CMP.
  - CMP: addr=j. B<=mem_rdata. Compare A against mem_rdata. Out of order → WRI; otherwise → ADVANCE decision.
  - WRI: we=1, addr=i, wdata=B. A<=B, so A tracks the new M[i]. Go to WRJ.
  - WRJ: we=1, addr=j, wdata=A (old value). Then ADVANCE decision.
  - ADVANCE (combinational, taken on exit from CMP or WRJ):
    - j<DEPTH-1: j++, go to RDB.
    - j==DEPTH-1 and i<DEPTH-2: i++, j=i+2, go to RDA.
    - otherwise: go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Output values in IDLE and DONE: mem_addr=0, mem_we=0, mem_wdata=0.
- `start` while busy is ignored. If start is still high when the FSM returns to IDLE, a new run begins.
- Counters are `ADDR_W` wide. No counter exceeds DEPTH-1, so there is no wrap.
- DEPTH=2: a single i iteration, j=1 only.

## Timing
- Reset (async assert, sync release): FSM=IDLE, i=0, j=1, A=B=0, desc latch=0, all outputs 0.
- Reset mid-run: outputs drop immediately, RAM is left partially sorted, and no further writes are issued. A write in flight at the reset edge is not completed.
- Cost per compare: 2 cycles with no swap, 4 with a swap. Add 1 RDA cycle per i.
- Start accepted at edge E0: cycles = Σ_{i=0}^{DEPTH-2} (1 + 2·(DEPTH-1-i)) + 2·swaps. DONE occupies the next cycle.
- RAM read latency must be exactly 1 cycle; a write is visible to a read 1 cycle later.

## Configuration
- `SORT_SIGNED_EN`:
  - Defined: A/B comparison treats operands as two's-complement signed.
  - Undefined: comparison is unsigned.
- No other behaviour or port changes either way.

## Test plan
- DEPTH=4, DATA_W=8, RAM {3,1,2,0}, desc=0 → RAM {0,1,2,3}; single done pulse; busy low after.
- RAM {0,1,2,3}, desc=0 → mem_we never asserted; done high in cycle 16 after the start-accept edge (15 busy cycles + DONE).
- RAM {1,2,3,4}, desc=1 → {4,3,2,1}; 6 swaps, so mem_we high for 12 cycles; done in cycle 28.
- RAM {80,7F,00,FF} hex, asc:
  - with `SORT_SIGNED_EN` → {80,FF,00,7F};
  - without it → {00,7F,80,FF}.
- Drop rst_n low during a WRI cycle → busy/done/mem_we go 0 with no clock edge; after release, start on {5,2,9,1} → {1,2,5,9}.
- DEPTH=2, RAM {5,2} → {2,5}, mem_we 2 cycles. A start pulse while busy causes no second run; start held high through DONE starts a second run.
